// File: rtl/io_pkg.sv
// Shared definitions for the IO return path: FSM states and packet geometry helpers.
package io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ENCODE,
    ST_SEND,
    ST_DONE
  } state_t;

  // Packet = {last, value, count}; helpers keep the geometry derived from PKT_W.
  function automatic int maxrun(input int pkt_w);
    return (1 << (pkt_w - 2)) - 1;
  endfunction

  function automatic int slots(input int pkt_w);
    return 32 / pkt_w;
  endfunction

  function automatic int last_bit(input int pkt_w);
    return pkt_w - 1;
  endfunction

  function automatic int value_bit(input int pkt_w);
    return pkt_w - 2;
  endfunction

endpackage

// File: rtl/run_length_scanner.sv
// Combinational run finder: length of the run of bits equal to elem[pos], scanning
// downward from pos, capped at cap (the run never extends below bit 0).
module run_length_scanner #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_W      = 6
) (
  input  logic [DATA_WIDTH-1:0]         elem,
  input  logic [$clog2(DATA_WIDTH)-1:0] pos,
  input  logic [CNT_W-1:0]              cap,
  output logic                          value,
  output logic [CNT_W-1:0]              count
);

  localparam int IW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] aligned;
  logic [IW-1:0]         idx;
  logic                  scanning;
  int                    run;

  // Left-align so elem[pos] sits at the MSB; the search then uses constant offsets.
  always_comb begin
    aligned  = elem << (IW'(DATA_WIDTH - 1) - pos);
    value    = aligned[DATA_WIDTH-1];
    idx      = '0;
    scanning = 1'b1;
    run      = 1;
    for (int i = 1; i < DATA_WIDTH; i++) begin
      idx = IW'(DATA_WIDTH - 1 - i);
      if (scanning && (i <= int'(pos)) && (aligned[idx] == value)) begin
        run = run + 1;
      end else begin
        scanning = 1'b0;
      end
    end
    if (run > int'(cap)) begin
      run = int'(cap);
    end
    count = CNT_W'(run);
  end

endmodule

// File: rtl/encoder_transmitter.sv
// Return-path encoder: fetches elements from RAM, run-length encodes them into
// packets packed MSB-first into 32-bit words, and hands each word to the CPU.
module encoder_transmitter
  import io_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int PKT_W         = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic [ADDRESS_WIDTH-1:0] Base_Address,
  input  logic [15:0]              Element_Count,
  output logic                     RAM_Read_En,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  input  logic [DATA_WIDTH-1:0]    RAM_Data,
  output logic [31:0]              CPU_Bus,
  output logic                     Bus_Valid,
  input  logic                     CPU_Ack,
  output logic                     Done_Sending
);

  localparam int MAXRUN    = maxrun(PKT_W);
  localparam int SLOTS     = slots(PKT_W);
  localparam int LAST_BIT  = last_bit(PKT_W);
  localparam int VALUE_BIT = value_bit(PKT_W);
  localparam int CNT_W     = PKT_W - 2;
  localparam int IW        = $clog2(DATA_WIDTH);
  localparam int SW        = $clog2(SLOTS + 1);

  state_t                   state;
  logic [DATA_WIDTH-1:0]    elem;
  logic [IW-1:0]            pos;
  logic [SW-1:0]            slot;
  logic [31:0]              word;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [15:0]              remaining;
  logic                     final_sent;
  logic                     elem_done;

  logic                     run_value;
  logic [CNT_W-1:0]         run_count;
  int                       pos_rem;
  logic                     exhausted;
  logic                     is_last;
  logic [PKT_W-1:0]         pkt;
  logic [31:0]              pkt_word;

  run_length_scanner #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_scanner (
    .elem  (elem),
    .pos   (pos),
    .cap   (CNT_W'(MAXRUN)),
    .value (run_value),
    .count (run_count)
  );

  // Packet assembly for the current ENCODE cycle; negative pos_rem means the element is used up.
  always_comb begin
    pos_rem   = int'(pos) - int'(run_count);
    exhausted = (pos_rem < 0);
    is_last   = exhausted && (remaining == 16'd1);
    pkt                  = '0;
    pkt[LAST_BIT]        = is_last;
    pkt[VALUE_BIT]       = run_value;
    pkt[VALUE_BIT-1:0]   = run_count;
    pkt_word  = {pkt, {(32 - PKT_W){1'b0}}} >> (int'(slot) * PKT_W);
  end

  assign RAM_Address = addr;
  assign CPU_Bus     = word;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      elem         <= '0;
      pos          <= '0;
      slot         <= '0;
      word         <= '0;
      addr         <= '0;
      remaining    <= '0;
      final_sent   <= 1'b0;
      elem_done    <= 1'b0;
      RAM_Read_En  <= 1'b0;
      Bus_Valid    <= 1'b0;
      Done_Sending <= 1'b0;
    end else begin
      RAM_Read_En  <= 1'b0;
      Done_Sending <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            addr      <= Base_Address;
            remaining <= Element_Count;
            if (Element_Count == 16'd0) begin
              state <= ST_DONE;
            end else begin
              state       <= ST_FETCH;
              RAM_Read_En <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          elem  <= RAM_Data;
          pos   <= IW'(DATA_WIDTH - 1);
          state <= ST_ENCODE;
        end
        ST_ENCODE: begin
          word <= word | pkt_word;
          pos  <= IW'(pos_rem);
          slot <= slot + 1'b1;
          if ((int'(slot) + 1 == SLOTS) || is_last) begin
            state      <= ST_SEND;
            Bus_Valid  <= 1'b1;
            final_sent <= is_last;
            elem_done  <= exhausted;
          end else if (exhausted) begin
            state       <= ST_FETCH;
            addr        <= addr + 1'b1;
            remaining   <= remaining - 16'd1;
            RAM_Read_En <= 1'b1;
          end
        end
        ST_SEND: begin
          // The word is frozen until the CPU acknowledges it.
          if (CPU_Ack) begin
            Bus_Valid <= 1'b0;
            word      <= '0;
            slot      <= '0;
            if (final_sent) begin
              state <= ST_DONE;
            end else if (elem_done) begin
              state       <= ST_FETCH;
              addr        <= addr + 1'b1;
              remaining   <= remaining - 16'd1;
              RAM_Read_En <= 1'b1;
            end else begin
              state <= ST_ENCODE;
            end
          end
        end
        ST_DONE: begin
          Done_Sending <= 1'b1;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
